axilite_slave_regs: RTL and testbench

- AXI4-Lite responder: a bank of NREGS read/write control registers on an axilite_if slave modport.
- Sits at the end of the AXI-Lite interconnect and exposes register contents to fabric logic.
- AR/R and AW/W/B channels run independently.
- Fabric logic gets per-register write strobes and a status snoop path.

---
 rtl/axilite_pkg.sv | 19 +
 rtl/axilite_if.sv | 35 +++
 rtl/axilite_slave_regs.sv | 211 +++++++++++++++++++++
 tb/tb_axilite_slave_regs.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite types: response codes, FSM state enums and the address decode helper.
package axilite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic {W_COLLECT, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  // Number of byte-offset address bits that sit below the word index.
  function automatic int addr_lsb(input int dwidth);
    return $clog2(dwidth / 8);
  endfunction

endpackage

// File: rtl/axilite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axilite_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);

  logic [AWIDTH-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DWIDTH-1:0]   wdata;
  logic [DWIDTH/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [AWIDTH-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DWIDTH-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axilite_slave_regs.sv
// AXI4-Lite register bank with independent read and write paths.
// Define AXIL_SLAVE_REGS_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axilite_slave_regs
  import axilite_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int NREGS  = 16,
  parameter logic [NREGS*DWIDTH-1:0] RESET_VALUES = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  axilite_if.slave                s_axil,
  output logic [NREGS*DWIDTH-1:0] regs_q,
  output logic [NREGS-1:0]        reg_wr,
  output logic [NREGS-1:0]        reg_rd
);

  localparam int ADDR_LSB = addr_lsb(DWIDTH);
  localparam int STRB_W   = DWIDTH / 8;

`ifdef AXIL_SLAVE_REGS_SLVERR_EN
  localparam resp_t OOR_RESP = RESP_SLVERR;
`else
  localparam resp_t OOR_RESP = RESP_OKAY;
`endif

  wr_state_t             wrState_q, wrState_d;
  logic                  awHeld_q, awHeld_d;
  logic                  wHeld_q, wHeld_d;
  logic [AWIDTH-1:0]     awAddr_q, awAddr_d;
  logic [DWIDTH-1:0]     wData_q, wData_d;
  logic [STRB_W-1:0]     wStrb_q, wStrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  resp_t                 bresp_q, bresp_d;
  logic [NREGS*DWIDTH-1:0] regs_d;
  logic [NREGS-1:0]      regWr_q, regWr_d;
  logic [AWIDTH-1:0]     wIdx;
  logic                  wInRange;

  rd_state_t             rdState_q, rdState_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DWIDTH-1:0]     rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;
  logic [AWIDTH-1:0]     rIdx;
  logic                  rInRange;
  logic                  arFire;

  assign wIdx     = awAddr_q >> ADDR_LSB;
  assign wInRange = (wIdx < AWIDTH'(NREGS));
  assign rIdx     = s_axil.araddr >> ADDR_LSB;
  assign rInRange = (rIdx < AWIDTH'(NREGS));
  assign arFire   = (rdState_q == R_IDLE) && s_axil.arvalid && arready_q;

  assign s_axil.awready = awready_q;
  assign s_axil.wready  = wready_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = arready_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;
  assign reg_wr         = regWr_q;

  // Address and data are captured independently; the commit happens one edge after both are held.
  always_comb begin
    wrState_d = wrState_q;
    awHeld_d  = awHeld_q;
    wHeld_d   = wHeld_q;
    awAddr_d  = awAddr_q;
    wData_d   = wData_q;
    wStrb_d   = wStrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    regWr_d   = '0;
    case (wrState_q)
      W_COLLECT: begin
        if (awHeld_q && wHeld_q) begin
          for (int i = 0; i < NREGS; i++) begin
            if (wIdx == AWIDTH'(i)) begin
              regWr_d[i] = 1'b1;
              for (int b = 0; b < STRB_W; b++) begin
                if (wStrb_q[b]) regs_d[i*DWIDTH + b*8 +: 8] = wData_q[b*8 +: 8];
              end
            end
          end
          bresp_d   = wInRange ? RESP_OKAY : OOR_RESP;
          bvalid_d  = 1'b1;
          awHeld_d  = 1'b0;
          wHeld_d   = 1'b0;
          wrState_d = W_RESP;
        end else begin
          if (s_axil.awvalid && awready_q) begin
            awHeld_d  = 1'b1;
            awAddr_d  = s_axil.awaddr;
            awready_d = 1'b0;
          end
          if (s_axil.wvalid && wready_q) begin
            wHeld_d  = 1'b1;
            wData_d  = s_axil.wdata;
            wStrb_d  = s_axil.wstrb;
            wready_d = 1'b0;
          end
        end
      end
      W_RESP: begin
        if (s_axil.bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wrState_d = W_COLLECT;
        end
      end
      default: wrState_d = W_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrState_q <= W_COLLECT;
      awHeld_q  <= 1'b0;
      wHeld_q   <= 1'b0;
      awAddr_q  <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      regs_q    <= RESET_VALUES;
      regWr_q   <= '0;
    end else begin
      wrState_q <= wrState_d;
      awHeld_q  <= awHeld_d;
      wHeld_q   <= wHeld_d;
      awAddr_q  <= awAddr_d;
      wData_q   <= wData_d;
      wStrb_q   <= wStrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
      regWr_q   <= regWr_d;
    end
  end

  // Read data samples regs_q before any same-edge write lands, so a collision returns the old value.
  always_comb begin
    rdState_d = rdState_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (rdState_q)
      R_IDLE: begin
        if (arFire) begin
          rdata_d = '0;
          for (int i = 0; i < NREGS; i++) begin
            if (rIdx == AWIDTH'(i)) rdata_d = regs_q[i*DWIDTH +: DWIDTH];
          end
          rresp_d   = rInRange ? RESP_OKAY : OOR_RESP;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          rdState_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axil.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rdState_d = R_IDLE;
        end
      end
      default: rdState_d = R_IDLE;
    endcase
  end

  // The read strobe marks the handshake cycle itself, so it is decoded from the live AR request.
  always_comb begin
    reg_rd = '0;
    if (arFire) begin
      for (int i = 0; i < NREGS; i++) begin
        if (rIdx == AWIDTH'(i)) reg_rd[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdState_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rdState_q <= rdState_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axilite_slave_regs.sv
// Directed bench for axilite_slave_regs; honours AXIL_SLAVE_REGS_SLVERR_EN for out-of-range responses.
module tb_axilite_slave_regs;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;
  localparam logic [NR*DW-1:0] RV = (512'h1111_1111 << 32) | (512'hDEAD_BEEF << 96) |
                                    (512'h4444_4444 << 128) | (512'hFFFF_FFFF << 160);
`ifdef AXIL_SLAVE_REGS_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR*DW-1:0] regs_q;
  logic [NR-1:0]    reg_wr;
  logic [NR-1:0]    reg_rd;
  logic [NR*DW-1:0] model;

  int errors = 0;
  int checks = 0;

  axilite_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  axilite_slave_regs #(
    .DWIDTH(DW), .AWIDTH(AW), .NREGS(NR), .RESET_VALUES(RV)
  ) dut (
    .clk(clk), .rst(rst), .s_axil(bus.slave),
    .regs_q(regs_q), .reg_wr(reg_wr), .reg_rd(reg_rd)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Independent AW/W delays in cycles; bready held high. Updates the bench model for in-range writes.
  task automatic applyWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int awDly, input int wDly,
                            output logic [1:0] resp, output logic [NR-1:0] wrSeen, output int pulses);
    bit awDone = 0;
    bit wDone = 0;
    bit bDone = 0;
    int cyc = 0;
    int idx;
    resp = 2'bxx;
    wrSeen = '0;
    pulses = 0;
    bus.awaddr = addr;
    bus.wdata = data;
    bus.wstrb = strb;
    bus.bready = 1'b1;
    while (!bDone && cyc < 40) begin
      bus.awvalid = !awDone && (cyc >= awDly);
      bus.wvalid = !wDone && (cyc >= wDly);
      @(negedge clk);
      if (bus.awvalid && bus.awready) awDone = 1;
      if (bus.wvalid && bus.wready) wDone = 1;
      wrSeen |= reg_wr;
      pulses += $countones(reg_wr);
      if (bus.bvalid) begin
        resp = bus.bresp;
        bDone = 1;
      end
      nextCycle();
      cyc++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    if (!bDone) checkOutput("write_timeout", 0, 1);
    idx = int'(addr >> 2);
    if (idx < NR) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx*DW + b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  // rready stays low for rDly cycles after the AR handshake; holdOk tracks rdata stability and arready low.
  task automatic applyRead(input logic [31:0] addr, input int rDly,
                           output logic [31:0] data, output logic [1:0] resp,
                           output logic [NR-1:0] rdSeen, output bit holdOk);
    bit arDone = 0;
    bit done = 0;
    bit first = 1;
    int cyc = 0;
    int waitCnt = 0;
    logic [31:0] firstData = '0;
    data = 'x;
    resp = 2'bxx;
    rdSeen = '0;
    holdOk = 1;
    bus.araddr = addr;
    bus.arvalid = 1'b1;
    bus.rready = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (!arDone) begin
        rdSeen |= reg_rd;
        if (bus.arready) arDone = 1;
      end else if (bus.rvalid) begin
        if (first) begin
          firstData = bus.rdata;
          first = 0;
        end else if (bus.rdata !== firstData) holdOk = 0;
        if (bus.arready !== 1'b0) holdOk = 0;
        if (bus.rready) begin
          data = bus.rdata;
          resp = bus.rresp;
          done = 1;
        end
      end
      nextCycle();
      cyc++;
      if (arDone && !done) begin
        bus.arvalid = 1'b0;
        bus.rready = (waitCnt >= rDly);
        waitCnt++;
      end
    end
    bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    if (!done) checkOutput("read_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] resp;
    logic [NR-1:0] seen;
    int pulses;
    logic [31:0] rdata;
    bit holdOk;

    model = RV;
    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;

    repeat (3) nextCycle();
    checkOutput("rst_regs", regs_q, RV);
    checkOutput("rst_reg3", regs_q[127:96], 32'hDEAD_BEEF);
    checkOutput("rst_arready", bus.arready, 1);
    checkOutput("rst_awready", bus.awready, 1);
    checkOutput("rst_wready", bus.wready, 1);
    checkOutput("rst_bvalid", bus.bvalid, 0);
    checkOutput("rst_rvalid", bus.rvalid, 0);
    checkOutput("rst_reg_wr", reg_wr, 0);
    rst = 1'b0;
    nextCycle();

    applyWrite(32'h08, 32'h1234_5678, 4'hF, 0, 3, resp, seen, pulses);
    checkOutput("aw_first_reg2", regs_q[95:64], 32'h1234_5678);
    checkOutput("aw_first_wr", seen, 16'h0004);
    checkOutput("aw_first_pulses", pulses, 1);
    checkOutput("aw_first_bresp", resp, 2'b00);

    applyWrite(32'h18, 32'h1234_5678, 4'hF, 3, 0, resp, seen, pulses);
    checkOutput("w_first_reg6", regs_q[223:192], 32'h1234_5678);
    checkOutput("w_first_wr", seen, 16'h0040);
    checkOutput("w_first_pulses", pulses, 1);
    checkOutput("w_first_bresp", resp, 2'b00);

    applyWrite(32'h1C, 32'h1234_5678, 4'hF, 0, 0, resp, seen, pulses);
    checkOutput("same_cyc_reg7", regs_q[255:224], 32'h1234_5678);
    checkOutput("same_cyc_wr", seen, 16'h0080);
    checkOutput("same_cyc_regs", regs_q, model);

    applyWrite(32'h14, 32'h0000_0000, 4'b0101, 0, 0, resp, seen, pulses);
    checkOutput("strb_reg5", regs_q[191:160], 32'hFF00_FF00);
    checkOutput("strb_wr", seen, 16'h0020);

    applyWrite(32'h10, 32'h0000_0000, 4'b0000, 0, 0, resp, seen, pulses);
    checkOutput("strb0_reg4", regs_q[159:128], 32'h4444_4444);
    checkOutput("strb0_wr", seen, 16'h0010);
    checkOutput("strb0_regs", regs_q, model);

    applyRead(32'h08, 5, rdata, resp, seen, holdOk);
    checkOutput("bp_rdata", rdata, 32'h1234_5678);
    checkOutput("bp_rresp", resp, 2'b00);
    checkOutput("bp_hold", holdOk, 1);
    checkOutput("bp_reg_rd", seen, 16'h0004);

    applyRead(32'h0C, 0, rdata, resp, seen, holdOk);
    checkOutput("rd_reg3", rdata, 32'hDEAD_BEEF);

    applyWrite(32'h40, 32'hAAAA_AAAA, 4'hF, 0, 0, resp, seen, pulses);
    checkOutput("oor_bresp", resp, OOR_RESP);
    checkOutput("oor_wr", seen, 0);
    checkOutput("oor_regs", regs_q, model);
    applyRead(32'h40, 0, rdata, resp, seen, holdOk);
    checkOutput("oor_rdata", rdata, 0);
    checkOutput("oor_rresp", resp, OOR_RESP);
    checkOutput("oor_reg_rd", seen, 0);

    // Collision: AW/W captured on one edge, so the commit edge coincides with the AR handshake edge.
    bus.awaddr = 32'h04; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
    nextCycle();
    bus.awvalid = 0; bus.wvalid = 0;
    bus.araddr = 32'h04; bus.arvalid = 1;
    @(negedge clk);
    checkOutput("col_reg_rd", reg_rd, 16'h0002);
    nextCycle();
    bus.arvalid = 0;
    @(negedge clk);
    checkOutput("col_rvalid", bus.rvalid, 1);
    checkOutput("col_rdata_old", bus.rdata, 32'h1111_1111);
    checkOutput("col_bvalid", bus.bvalid, 1);
    checkOutput("col_reg_wr", reg_wr, 16'h0002);
    nextCycle();
    bus.rready = 1; bus.bready = 1;
    nextCycle();
    bus.rready = 0; bus.bready = 0;
    model[63:32] = 32'hCAFE_F00D;
    applyRead(32'h04, 0, rdata, resp, seen, holdOk);
    checkOutput("col_rdata_new", rdata, 32'hCAFE_F00D);

    bus.awaddr = 32'h18; bus.wdata = 32'h5555_5555; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
    nextCycle();
    bus.awvalid = 0; bus.wvalid = 0;
    nextCycle();
    checkOutput("pre_rst_bvalid", bus.bvalid, 1);
    checkOutput("pre_rst_reg6", regs_q[223:192], 32'h5555_5555);
    rst = 1;
    nextCycle();
    checkOutput("mid_rst_bvalid", bus.bvalid, 0);
    checkOutput("mid_rst_regs", regs_q, RV);
    checkOutput("mid_rst_awready", bus.awready, 1);
    rst = 0;
    bus.bready = 1;
    pulses = 0;
    repeat (3) begin
      nextCycle();
      if (bus.bvalid) pulses++;
    end
    bus.bready = 0;
    checkOutput("post_rst_no_b", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
